// File: rtl/pipe_prefix_adder.sv
// -----------------------------------------------------------------------------
// pipe_prefix_adder
//
// Pipelined add/subtract unit built on a Kogge-Stone parallel-prefix carry
// network. The operation is A + B + cin (sub=0) or A - B = A + ~B + 1 (sub=1).
// A configurable number of register stages is spread evenly over the prefix
// levels. The first boundary always sits right after bit generate/propagate,
// and the last one always holds the final sum/cout/ovf. Flow control is a
// single global advance enable, so a stalled output freezes the whole pipe.
//
// Parameters
//   WIDTH  : operand / sum width in bits (8..128, power of two)
//   STAGES : register stages from acceptance to result (1..log2(WIDTH)+1)
//
// Ports
//   clk       in   sole clock, rising edge
//   rst       in   synchronous active-high reset, empties the pipeline
//   in_valid  in   operands present this cycle
//   in_ready  out  operands are accepted this cycle (pipeline advance enable)
//   a, b      in   operands, WIDTH bits
//   cin       in   carry-in, ignored when sub=1
//   sub       in   0: A+B+cin, 1: A-B
//   out_valid out  result present
//   out_ready in   downstream takes the result
//   sum       out  result modulo 2^WIDTH
//   cout      out  carry out of the MSB (for subtraction 1 = no borrow)
//   ovf       out  signed two's-complement overflow
// -----------------------------------------------------------------------------
module pipe_prefix_adder #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int LEVELS = $clog2(WIDTH);
  // Distance spanned by the last prefix level, which is folded into the
  // output stage together with the sum formation.
  localparam int FINAL_DIST = WIDTH / 2;

  // Register boundary j (0..STAGES-2) is placed after prefix level
  // floor(j*LEVELS/(STAGES-1)). Boundary 0 therefore lands on level 0
  // (bit generate/propagate). The output register is always present and
  // accounts for the remaining stage.
  function automatic bit is_reg(input int k);
    bit r;
    r = 1'b0;
    for (int j = 0; j < STAGES - 1; j++) begin
      if ((j * LEVELS) / (STAGES - 1) == k) r = 1'b1;
    end
    return r;
  endfunction

  // Global advance enable: the pipe moves unless a result is stuck at the
  // output. Everything, valid bits included, holds when it is low.
  logic en;
  logic out_valid_q;

  assign en       = !out_valid_q || out_ready;
  assign in_ready = en || rst;

  // ---------------------------------------------------------------------------
  // Prefix levels 0 .. LEVELS-1. Each level exposes its result on *_o, either
  // straight through or from its own register bank.
  //   g_o/p_o : group generate/propagate after this level
  //   rp_o    : raw bit propagate, needed for the final sum XOR
  //   c0_o    : effective carry-in, needed for sum[0]
  //   v_o     : transaction valid bit
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < LEVELS; gi++) begin : lvl
    localparam bit IS_REG = is_reg(gi);

    logic [WIDTH-1:0] g_d, p_d, rp_d;
    logic [WIDTH-1:0] g_o, p_o, rp_o;
    logic             c0_d, v_d;
    logic             c0_o, v_o;

    if (gi == 0) begin : bitgen
      logic [WIDTH-1:0] b_eff;

      assign b_eff = sub ? ~b : b;
      assign c0_d  = sub | cin;
      assign rp_d  = a ^ b_eff;
      assign p_d   = rp_d;
      // The carry-in is folded into bit 0 so that G[i] of the final level is
      // directly the carry into bit i+1.
      assign g_d   = (a & b_eff) | {{(WIDTH-1){1'b0}}, rp_d[0] & c0_d};
      assign v_d   = in_valid;
    end else begin : pfx
      localparam int DIST = 1 << (gi - 1);
      localparam logic [WIDTH-1:0] LOW_MASK = {WIDTH{1'b1}} >> (WIDTH - DIST);

      logic [WIDTH-1:0] g_s, p_s;

      assign g_s  = lvl[gi-1].g_o;
      assign p_s  = lvl[gi-1].p_o;
      // Shifting in zeros leaves the low DIST bits of G unchanged; the low
      // mask does the same for P.
      assign g_d  = g_s | (p_s & (g_s << DIST));
      assign p_d  = p_s & ((p_s << DIST) | LOW_MASK);
      assign rp_d = lvl[gi-1].rp_o;
      assign c0_d = lvl[gi-1].c0_o;
      assign v_d  = lvl[gi-1].v_o;
    end

    if (IS_REG) begin : stg
      logic [WIDTH-1:0] g_q, p_q, rp_q;
      logic             c0_q, v_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          g_q  <= '0;
          p_q  <= '0;
          rp_q <= '0;
          c0_q <= 1'b0;
          v_q  <= 1'b0;
        end else if (en) begin
          g_q  <= g_d;
          p_q  <= p_d;
          rp_q <= rp_d;
          c0_q <= c0_d;
          v_q  <= v_d;
        end
      end

      assign g_o  = g_q;
      assign p_o  = p_q;
      assign rp_o = rp_q;
      assign c0_o = c0_q;
      assign v_o  = v_q;
    end else begin : thru
      assign g_o  = g_d;
      assign p_o  = p_d;
      assign rp_o = rp_d;
      assign c0_o = c0_d;
      assign v_o  = v_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Output stage: last prefix level, sum/cout/ovf formation, result register.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] fin_g;
  logic [WIDTH-1:0] carries;
  logic [WIDTH-1:0] sum_d, sum_q;
  logic             cout_d, cout_q;
  logic             ovf_d, ovf_q;
  logic             out_valid_d;

  // After this level fin_g[i] is G[i:0], i.e. the carry out of bit i.
  assign fin_g = lvl[LEVELS-1].g_o |
                 (lvl[LEVELS-1].p_o & (lvl[LEVELS-1].g_o << FINAL_DIST));

  always_comb begin
    carries     = {fin_g[WIDTH-2:0], lvl[LEVELS-1].c0_o};
    sum_d       = lvl[LEVELS-1].rp_o ^ carries;
    cout_d      = fin_g[WIDTH-1];
    // Overflow is the carry into the MSB differing from the carry out of it.
    ovf_d       = fin_g[WIDTH-1] ^ fin_g[WIDTH-2];
    out_valid_d = lvl[LEVELS-1].v_o;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else if (en) begin
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipe_prefix_adder.sv
// -----------------------------------------------------------------------------
// tb_pipe_prefix_adder
//
// Scoreboard bench for pipe_prefix_adder. The driver pushes the expected
// result for every accepted operation; an independent monitor pops and
// compares whenever a result is handed over (out_valid & out_ready).
// Directed vectors carry hand-derived expectations; the back-to-back burst
// uses a plain wide-add reference model.
// -----------------------------------------------------------------------------
module tb_pipe_prefix_adder #(
  parameter int W = 64,
  parameter int S = 3
);

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         cin, sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout, ovf;

  always #5 clk = ~clk;

  pipe_prefix_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           issue;
    bit           chk_lat;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  int   n_out = 0;

  localparam logic [W-1:0] ONES = {W{1'b1}};
  localparam logic [W-1:0] MAXP = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MINN = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] PAT_A = {(W/2){2'b10}};
  localparam logic [W-1:0] PAT_5 = {(W/2){2'b01}};

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t mk(input logic [W-1:0] s, input logic c, input logic o, input bit lat);
    exp_t e;
    e.sum = s; e.cout = c; e.ovf = o; e.issue = 0; e.chk_lat = lat;
    return e;
  endfunction

  // Reference: plain (W+1)-bit addition, overflow from operand/result signs.
  function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                                 input logic tcin, input logic tsub, input bit lat);
    logic [W-1:0] bb;
    logic [W:0]   r;
    logic         c0;
    bb = tsub ? ~tb_ : tb_;
    c0 = tsub ? 1'b1 : tcin;
    r  = {1'b0, ta} + {1'b0, bb} + {{W{1'b0}}, c0};
    return mk(r[W-1:0], r[W], (ta[W-1] == bb[W-1]) && (r[W-1] != ta[W-1]), lat);
  endfunction

  function automatic logic [W-1:0] rnd_w();
    logic [W-1:0] r;
    for (int k = 0; k < W; k++) r[k] = 1'($urandom_range(1, 0));
    return r;
  endfunction

  // Drive one operation (called just after a rising edge) and hold it until
  // accepted; push its expectation when it is.
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                      input logic tcin, input logic tsub, input exp_t e, input bit push);
    int waited;
    a = ta; b = tb_; cin = tcin; sub = tsub; in_valid = 1'b1;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      n_chk++; n_bad++;
      $display("FAIL accept_timeout: in_ready=%b after %0d cycles, required 1", in_ready, waited);
    end else if (push) begin
      e.issue = cyc;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic check1(input string name, input logic act, input logic req);
    n_chk++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %b, required %b", name, act, req);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: scoreboard pops, latency and stall-stability checks.
  // ---------------------------------------------------------------------------
  logic [W-1:0] prev_sum;
  logic         prev_cout, prev_ovf;
  bit           hold_prev = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst && hold_prev) begin
      n_chk++;
      if (!out_valid || sum !== prev_sum || cout !== prev_cout || ovf !== prev_ovf) begin
        n_bad++;
        $display("FAIL stall_stable: got v=%b sum=%h cout=%b ovf=%b, required v=1 sum=%h cout=%b ovf=%b",
                 out_valid, sum, cout, ovf, prev_sum, prev_cout, prev_ovf);
      end
    end
    if (!rst && out_valid && out_ready) begin
      n_chk++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_result: got sum=%h cout=%b ovf=%b, required no output", sum, cout, ovf);
      end else begin
        e = sb.pop_front();
        n_out++;
        if (sum !== e.sum || cout !== e.cout || ovf !== e.ovf) begin
          n_bad++;
          $display("FAIL result_%0d: got sum=%h cout=%b ovf=%b, required sum=%h cout=%b ovf=%b",
                   n_out, sum, cout, ovf, e.sum, e.cout, e.ovf);
        end else begin
          $display("result %0d: sum=%h cout=%b ovf=%b ok", n_out, sum, cout, ovf);
        end
        if (e.chk_lat) begin
          n_chk++;
          if (cyc - e.issue != S) begin
            n_bad++;
            $display("FAIL latency_%0d: got %0d cycles, required %0d", n_out, cyc - e.issue, S);
          end
        end
      end
    end
    hold_prev = !rst && out_valid && !out_ready;
    prev_sum  = sum;
    prev_cout = cout;
    prev_ovf  = ovf;
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [W-1:0] ra, rb;
    logic         rc, rs;
    int           waited;

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;

    // Reset behaviour
    @(negedge clk);
    check1("in_ready_in_reset", in_ready, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check1("rst_out_valid", out_valid, 1'b0);
    check1("rst_cout", cout, 1'b0);
    check1("rst_ovf", ovf, 1'b0);
    check1("rst_sum_zero", (sum == '0), 1'b1);
    check1("in_ready_after_reset", in_ready, 1'b1);
    @(posedge clk); #1;

    // Directed vectors, back-to-back, hand-derived results
    send(ONES, W'(1), 1'b0, 1'b0, mk('0, 1'b1, 1'b0, 1'b1), 1'b1);
    send(MAXP, W'(1), 1'b0, 1'b0, mk(MINN, 1'b0, 1'b1, 1'b1), 1'b1);
    send(W'(5), W'(7), 1'b0, 1'b1, mk({{(W-1){1'b1}}, 1'b0}, 1'b0, 1'b0, 1'b1), 1'b1);
    send('0, '0, 1'b1, 1'b0, mk(W'(1), 1'b0, 1'b0, 1'b1), 1'b1);
    send(PAT_A, PAT_5, 1'b1, 1'b0, mk('0, 1'b1, 1'b0, 1'b1), 1'b1);
    send(MINN, W'(1), 1'b0, 1'b1, mk(MAXP, 1'b1, 1'b1, 1'b1), 1'b1);
    send(MAXP, MAXP, 1'b1, 1'b1, mk('0, 1'b1, 1'b0, 1'b1), 1'b1);
    send('0, W'(1), 1'b0, 1'b1, mk(ONES, 1'b0, 1'b0, 1'b1), 1'b1);
    send(MINN, MINN, 1'b0, 1'b0, mk('0, 1'b1, 1'b1, 1'b1), 1'b1);
    send(W'(3), W'(4), 1'b1, 1'b0, mk(W'(8), 1'b0, 1'b0, 1'b1), 1'b1);
    // Isolated op after a bubble gap
    repeat (2) @(posedge clk);
    #1;
    send(W'(9), W'(2), 1'b1, 1'b1, mk(W'(7), 1'b1, 1'b0, 1'b1), 1'b1);

    // 100 back-to-back operations against the reference model
    for (int i = 0; i < 100; i++) begin
      ra = rnd_w(); rb = rnd_w();
      rc = 1'($urandom_range(1, 0)); rs = 1'($urandom_range(1, 0));
      send(ra, rb, rc, rs, model(ra, rb, rc, rs, 1'b1), 1'b1);
    end

    // Drain, then fill the pipe with the output stalled
    waited = 0;
    while (sb.size() != 0 && waited < 100) begin @(posedge clk); waited++; end
    #1;
    out_ready = 1'b0;
    for (int i = 0; i < S; i++) begin
      ra = rnd_w(); rb = rnd_w();
      send(ra, rb, 1'b1, 1'(i & 1), model(ra, rb, 1'b1, 1'(i & 1), 1'b0), 1'b1);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check1("in_ready_stalled", in_ready, 1'b0);
      check1("out_valid_stalled", out_valid, 1'b1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    // New operations accepted while the stalled results drain
    for (int i = 0; i < 4; i++) begin
      ra = rnd_w(); rb = rnd_w();
      send(ra, rb, 1'b0, 1'(i & 1), model(ra, rb, 1'b0, 1'(i & 1), 1'b1), 1'b1);
    end

    // Reset with a full pipe: in-flight work must vanish
    waited = 0;
    while (sb.size() != 0 && waited < 100) begin @(posedge clk); waited++; end
    #1;
    out_ready = 1'b0;
    for (int i = 0; i < S; i++) begin
      send(rnd_w(), rnd_w(), 1'b0, 1'b0, mk('0, 1'b0, 1'b0, 1'b0), 1'b0);
    end
    rst = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check1("out_valid_after_mid_reset", out_valid, 1'b0);
    end
    @(posedge clk); #1;
    send(W'(100), W'(23), 1'b1, 1'b0, mk(W'(124), 1'b0, 1'b0, 1'b1), 1'b1);

    // Everything pushed must come out
    waited = 0;
    while (sb.size() != 0 && waited < 100) begin @(posedge clk); waited++; end
    @(negedge clk);
    if (sb.size() != 0) begin
      n_chk++; n_bad++;
      $display("FAIL drain: %0d results outstanding, required 0", sb.size());
    end
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_prefix_adder.md
PIPE_PREFIX_ADDER -- requirements
Module: pipe_prefix_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 64, meaning operand and sum width in bits (legal 8..128, power of two).
REQ-002 The block SHALL have parameter STAGES, default 3, meaning pipeline register stages from input acceptance to result (legal 1..log2(WIDTH)+1).
REQ-003 Port clk, input, 1, sole clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1, reset; synchronous, active-high.
REQ-005 Port in_valid, input, 1, operands present this cycle.
REQ-006 Port in_ready, output, 1, block accepts operands this cycle.
REQ-007 Port a, input, WIDTH, operand A.
REQ-008 Port b, input, WIDTH, operand B.
REQ-009 Port cin, input, 1, carry-in (ignored when sub=1).
REQ-010 Port sub, input, 1, 0 = A+B+cin, 1 = A-B (computed as A + ~B + 1).
REQ-011 Port out_valid, output, 1, result present.
REQ-012 Port out_ready, input, 1, downstream accepts result.
REQ-013 Port sum, output, WIDTH, result modulo 2^WIDTH.
REQ-014 Port cout, output, 1, carry out of bit WIDTH-1 (for sub: 1 = no borrow).
REQ-015 Port ovf, output, 1, signed two's-complement overflow of the operation.

Function
REQ-016 Bit generate/propagate SHALL be g[i]=a[i]&b'[i], p[i]=a[i]^b'[i], b' = sub ? ~b : b, carry-in c0 = sub ? 1 : cin.
REQ-017 Group carries SHALL be formed by a Kogge-Stone prefix network of log2(WIDTH) levels with c0 folded into bit 0 generate.
REQ-018 sum[0] SHALL be p[0]^c0; sum[i] SHALL be p[i]^G[i-1:0] for i>=1; cout SHALL be G[WIDTH-1:0].
REQ-019 ovf SHALL equal carry into bit WIDTH-1 XOR cout.
REQ-020 The STAGES register boundaries SHALL be distributed evenly over the prefix levels; stage 1 registers p/g, last stage registers sum/cout/ovf.
REQ-021 Latency SHALL be exactly STAGES cycles from an accepted input (in_valid&in_ready) to out_valid with no stall.
REQ-022 Each stage SHALL carry a valid bit; pipeline advance enable en = !out_valid | out_ready.
REQ-023 in_ready SHALL equal en; when en=0 all stage registers and valid bits SHALL hold.
REQ-024 Empty bubbles (in_valid=0 on acceptance) SHALL propagate as valid=0 and SHALL NOT raise out_valid.
REQ-025 Throughput SHALL be one operation per cycle while out_ready=1.
REQ-026 sum/cout/ovf SHALL remain stable while out_valid=1 and out_ready=0.
REQ-027 Simultaneous input acceptance and output drain in one cycle SHALL lose no transaction.
REQ-028 Results SHALL emerge in acceptance order; sub and cin SHALL travel with their operands.

Reset
REQ-029 While rst=1 on a clock edge all valid bits SHALL clear; out_valid=0, sum=0, cout=0, ovf=0 after that edge.
REQ-030 in_ready SHALL be 1 during and after reset (pipeline empty).
REQ-031 Reset mid-operation SHALL discard all in-flight transactions; no stale result SHALL appear afterwards.

Verification (WIDTH=64, STAGES=3)
REQ-032 a=FFFF_FFFF_FFFF_FFFF, b=1, cin=0, sub=0 -> 3 cycles later sum=0, cout=1, ovf=0.
REQ-033 a=7FFF_FFFF_FFFF_FFFF, b=1, sub=0 -> sum=8000_0000_0000_0000, cout=0, ovf=1; a=5, b=7, sub=1 -> sum=FFFF_FFFF_FFFF_FFFE, cout=0, ovf=0.
REQ-034 Back-to-back 100 random operations with out_ready=1 -> 100 results in order, one per cycle, matching reference model.
REQ-035 Hold out_ready=0 for 5 cycles with pipeline full -> in_ready=0, outputs stable, no loss; release -> remaining results drain in order.
REQ-036 Assert rst for 1 cycle with 3 operations in flight -> out_valid=0 on following cycles until a new accepted input appears 3 cycles later.
REQ-037 Repeat REQ-032..034 for WIDTH=8, STAGES=1 and WIDTH=128, STAGES=8 -> same functional results, latency equal to STAGES.
